table_symbol_mp: RTL and testbench
==================================

# table_symbol_mp

Multi-read-port successor to the single-port symbol table. One write port and NRD independent registered read ports sit over a DEPTH x WIDTH array. A built-in clear sequencer sweeps every entry to INIT_VAL after reset or on request. It serves as the shared lookup store for symbol and configuration data, where several consumers read in parallel with one writer.

## Interface
- DEPTH, 32, number of entries, at least 2; need not be a power of two
- WIDTH, 32, entry width in bits
- NRD, 2, number of read ports, at least 1
- INIT_VAL, 0, WIDTH-bit value written to every entry by the clear sweep
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  one-cycle request to start a clear sweep
- busy  out  1  high while a sweep runs; all accesses are ignored while high
- we  in  1  write enable
- waddr  in  AW  write address, where AW = $clog2(DEPTH)
- wdata  in  WIDTH  write data
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*WIDTH  packed registered read data
- rd_valid  out  NRD  per-port one-cycle pulse marking new rd_data

## Operation
- FSM has two states:
  - INIT: sweep counter writes INIT_VAL to entry cnt, then cnt+1. After writing DEPTH-1 it moves to IDLE.
  - IDLE: normal access. clr=1 moves it to INIT with cnt=0.
- busy=1 exactly while the FSM is in INIT.
- clr asserted during INIT restarts the sweep at cnt=0.
- Write: in IDLE, we=1 and waddr<DEPTH writes wdata to the entry at that edge. Out-of-range writes are dropped.
- Read: in IDLE, rd_en[i]=1 samples entry rd_addr[i].
  - Data appears on rd_data[i] with rd_valid[i]=1 on the next cycle.
  - Out-of-range addresses return all zeros with rd_valid still pulsed.
- rd_data[i] holds its last value when no read is issued. rd_valid[i] falls after one cycle.
- Any number of ports may read the same address in the same cycle; each port receives identical data.
- Same-cycle read and write to the same address: the read returns the old contents (read-first) unless TABLE_BYPASS_EN is defined.
- Cycle with clr=1 in IDLE:
  - Reads in that cycle are serviced from the pre-clear contents.
  - A write in that cycle is discarded; clr has priority.
- In INIT, we and rd_en are ignored. rd_valid stays 0 and rd_data holds.

## Timing
- Reset values: busy=1, rd_valid=0, rd_data=0, FSM=INIT, cnt=0. Array contents are not reset directly; the sweep initialises them.
- After rst_n rises, edge k (k=1..DEPTH) writes entry k-1. The FSM enters IDLE at edge DEPTH, so busy is low from then on.
- The first access is accepted at edge DEPTH+1.
- Clear latency: DEPTH cycles from the edge sampling clr to busy falling.
- Read latency: 1 cycle, with full throughput on every port.
- Reset asserted mid-sweep or mid-read:
  - busy rises immediately and rd_valid clears immediately.
  - The sweep restarts from entry 0 after release.

## Configuration
- TABLE_BYPASS_EN defined:
  - A same-cycle write to the address a port is reading forwards wdata to that port's rd_data on the next cycle (write-first).
  - A dropped out-of-range write is not forwarded.
- TABLE_BYPASS_EN undefined: read-first; no forwarding path is present.

## Structure
- Package table_pkg holds:
  - state enum {ST_INIT, ST_IDLE}
  - address-width helper function
  - default parameter constants
- Sub-module table_rd_port holds one registered read port: out-of-range check, rd_data/rd_valid registers, and the optional bypass mux. It is instantiated NRD times with a generate loop.
- Top level holds the array, write decode, sweep counter and FSM.

## Test plan
- Reset release with DEPTH=32, INIT_VAL=0xA5A5A5A5 -> busy high for 32 cycles; afterwards a read of every address returns 0xA5A5A5A5.
- Write 0x1234 to addr 5, then on the next cycle read addr 5 on both ports -> both rd_data=0x1234 with rd_valid pulsed one cycle later.
- Write 0xBEEF to addr 3 while port 0 reads addr 3 (previously 0x1111) -> 0x1111 without the macro; 0xBEEF with TABLE_BYPASS_EN.
- Pulse clr after filling entries with distinct values -> 32 busy cycles; writes and reads in that window produce no rd_valid; all entries read INIT_VAL afterwards.
- DEPTH=20: write 0x77 to addr 25, then read addr 25 -> rd_data=0 with rd_valid=1, and no entry is modified.
- Assert rst_n low at sweep cnt=10 -> busy stays high, rd_valid=0; after release the full 20-cycle sweep repeats from entry 0.

Source files
------------

// File: rtl/table_pkg.sv
// table_pkg: shared types and constants for the multi-read-port symbol table.
//   - state_t      : sweep/access FSM states
//   - addr_w()     : address width for a given table depth
//   - DEF_*        : default parameter values
// Optional feature macro used by the design: TABLE_BYPASS_EN (write-first reads).
package table_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam int          DEF_DEPTH    = 32;
    localparam int          DEF_WIDTH    = 32;
    localparam int          DEF_NRD      = 2;
    localparam logic [31:0] DEF_INIT_VAL = 32'h0;

    // Address width for a table of 'depth' entries; never below one bit.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/table_rd_port.sv
// table_rd_port: one registered read port of the symbol table.
// Macro: TABLE_BYPASS_EN adds the write-to-read forwarding path.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_en         : read accepted this cycle (already gated by FSM state)
//   i_addr       : read address
//   i_word       : array word at i_addr (don't-care when i_addr out of range)
//   i_wr_en      : committed write this cycle   (TABLE_BYPASS_EN only)
//   i_waddr      : committed write address      (TABLE_BYPASS_EN only)
//   i_wdata      : committed write data         (TABLE_BYPASS_EN only)
//   o_data       : registered read data, holds between reads
//   o_valid      : one-cycle pulse marking new o_data
module table_rd_port
    import table_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_word,
`ifdef TABLE_BYPASS_EN
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
`endif
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic             w_in_range;
    logic [WIDTH-1:0] w_data_p0;
    logic [WIDTH-1:0] r_data_p1;
    logic             r_vld_p1;

    assign w_in_range = ({1'b0, i_addr} < DEPTH_W);

    always_comb begin
        w_data_p0 = '0;
        if (w_in_range) begin
            w_data_p0 = i_word;
`ifdef TABLE_BYPASS_EN
            // i_wr_en is only high for in-range writes, so a dropped write
            // can never match here.
            if (i_wr_en && (i_waddr == i_addr)) begin
                w_data_p0 = i_wdata;
            end
`endif
        end
    end

    // ---- stage p0 -> p1: registered read result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= i_en;
            if (i_en) begin
                r_data_p1 <= w_data_p0;
            end
        end
    end

    assign o_data  = r_data_p1;
    assign o_valid = r_vld_p1;

endmodule

// File: rtl/table_symbol_mp.sv
// table_symbol_mp: DEPTH x WIDTH table with one write port, NRD registered
// read ports and a clear sequencer that sweeps every entry to INIT_VAL after
// reset or on a clr request.
// Macro: TABLE_BYPASS_EN selects write-first same-address reads
//        (default build is read-first).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : one-cycle request to start a clear sweep
//   busy       : high while the sweep runs; all accesses ignored
//   we, waddr, wdata : write port (out-of-range writes dropped)
//   rd_en      : per-port read enable
//   rd_addr    : packed read addresses, port i at [i*AW +: AW]
//   rd_data    : packed registered read data, port i at [i*WIDTH +: WIDTH]
//   rd_valid   : per-port one-cycle pulse marking new rd_data
module table_symbol_mp
    import table_pkg::*;
#(
    parameter int               DEPTH    = DEF_DEPTH,
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               NRD      = DEF_NRD,
    parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(DEF_INIT_VAL),
    localparam int              AW       = addr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    output logic                 busy,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_idle;
    logic             w_we_eff;

    assign w_idle = (r_state == ST_IDLE);
    assign busy   = (r_state == ST_INIT);

    // clr in IDLE wins over a same-cycle write.
    assign w_we_eff = w_idle && !clr && we && ({1'b0, waddr} < DEPTH_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (clr) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Array is deliberately not reset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (busy) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else if (w_we_eff) begin
            r_mem[waddr] <= wdata;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]    w_addr;
        logic [AW-1:0]    w_idx;
        logic [WIDTH-1:0] w_word;

        assign w_addr = rd_addr[gi*AW +: AW];
        // Keep the array lookup in bounds; the port zeroes out-of-range data.
        assign w_idx  = ({1'b0, w_addr} < DEPTH_W) ? w_addr : '0;
        assign w_word = r_mem[w_idx];

        table_rd_port #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_rd_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (rd_en[gi] && w_idle),
            .i_addr  (w_addr),
            .i_word  (w_word),
`ifdef TABLE_BYPASS_EN
            .i_wr_en (w_we_eff),
            .i_waddr (waddr),
            .i_wdata (wdata),
`endif
            .o_data  (rd_data[gi*WIDTH +: WIDTH]),
            .o_valid (rd_valid[gi])
        );
    end

endmodule

// File: tb/tb_table_symbol_mp.sv
// Scoreboard bench for table_symbol_mp: two instances (DEPTH=32 and DEPTH=20),
// expected read data queued per port at issue time, popped by a negedge monitor.
module tb_table_symbol_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=32, INIT_VAL=A5A5A5A5
    logic        rst_n_a, clr_a, we_a, busy_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [1:0]  rd_en_a, rd_valid_a;
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;

    // Instance B: DEPTH=20, INIT_VAL=5A
    logic        rst_n_b, clr_b, we_b, busy_b;
    logic [4:0]  waddr_b;
    logic [31:0] wdata_b;
    logic [1:0]  rd_en_b, rd_valid_b;
    logic [9:0]  rd_addr_b;
    logic [63:0] rd_data_b;

    table_symbol_mp #(.DEPTH(32), .WIDTH(32), .NRD(2), .INIT_VAL(32'hA5A5A5A5)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .clr(clr_a), .busy(busy_a), .we(we_a),
        .waddr(waddr_a), .wdata(wdata_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    table_symbol_mp #(.DEPTH(20), .WIDTH(32), .NRD(2), .INIT_VAL(32'h0000005A)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .clr(clr_b), .busy(busy_b), .we(we_b),
        .waddr(waddr_b), .wdata(wdata_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] q_a0[$];
    logic [31:0] q_a1[$];
    logic [31:0] q_b0[$];
    logic [31:0] q_b1[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic [31:0] d);
        logic [31:0] e;
        int sz;
        if (v !== 1'b1) return;
        case (id)
            0: sz = q_a0.size();
            1: sz = q_a1.size();
            2: sz = q_b0.size();
            default: sz = q_b1.size();
        endcase
        if (sz == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_valid port%0d: got data=%h required=no rd_valid (t=%0t)", id, d, $time);
            return;
        end
        case (id)
            0: e = q_a0.pop_front();
            1: e = q_a1.pop_front();
            2: e = q_b0.pop_front();
            default: e = q_b1.pop_front();
        endcase
        chk($sformatf("rd_data_port%0d", id), {32'h0, d}, {32'h0, e});
    endtask

    always @(negedge clk) begin
        mon(0, rd_valid_a[0], rd_data_a[31:0]);
        mon(1, rd_valid_a[1], rd_data_a[63:32]);
        mon(2, rd_valid_b[0], rd_data_b[31:0]);
        mon(3, rd_valid_b[1], rd_data_b[63:32]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy falls; 0 means it never fell within the bound.
    task automatic wait_sweep(input string nm, input logic is_b, input int exp_n);
        int got;
        got = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (!(is_b ? busy_b : busy_a)) begin
                got = n;
                break;
            end
        end
        chk(nm, 64'(got), 64'(exp_n));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_a = 0; clr_a = 0; we_a = 0; waddr_a = 0; wdata_a = 0; rd_en_a = 0; rd_addr_a = 0;
        rst_n_b = 0; clr_b = 0; we_b = 0; waddr_b = 0; wdata_b = 0; rd_en_b = 0; rd_addr_b = 0;
        repeat (3) step();

        chk("reset_busy_a", 64'(busy_a), 64'd1);
        chk("reset_valid_a", 64'(rd_valid_a), 64'd0);
        chk("reset_data_a", rd_data_a, 64'd0);

        // Power-up sweep: busy for 32 edges, then every entry reads INIT_VAL.
        rst_n_a = 1;
        wait_sweep("init_sweep_a", 1'b0, 32);
        for (int a = 0; a < 32; a++) begin
            rd_en_a = 2'b11;
            rd_addr_a = {5'(31 - a), 5'(a)};
            q_a0.push_back(32'hA5A5A5A5);
            q_a1.push_back(32'hA5A5A5A5);
            step();
        end
        rd_en_a = 0;

        // Write then read on both ports.
        we_a = 1; waddr_a = 5; wdata_a = 32'h1234;
        step();
        we_a = 0;
        rd_en_a = 2'b11; rd_addr_a = {5'd5, 5'd5};
        q_a0.push_back(32'h1234);
        q_a1.push_back(32'h1234);
        step();
        rd_en_a = 0;
        step();
        chk("valid_pulse_a", 64'(rd_valid_a), 64'd0);
        chk("data_hold_a", rd_data_a, {32'h1234, 32'h1234});

        // Same-cycle read/write of one address.
        we_a = 1; waddr_a = 3; wdata_a = 32'h1111;
        step();
        wdata_a = 32'hBEEF;
        rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd3};
`ifdef TABLE_BYPASS_EN
        q_a0.push_back(32'hBEEF);
`else
        q_a0.push_back(32'h1111);
`endif
        step();
        we_a = 0; rd_en_a = 0;

        // Fill with distinct values.
        for (int i = 0; i < 32; i++) begin
            we_a = 1; waddr_a = 5'(i); wdata_a = 32'h1000 + 32'(i);
            step();
        end
        we_a = 0;
        rd_en_a = 2'b11; rd_addr_a = {5'd30, 5'd7};
        q_a0.push_back(32'h1007);
        q_a1.push_back(32'h101E);
        step();

        // clr cycle: reads see pre-clear data, the write is discarded.
        clr_a = 1; we_a = 1; waddr_a = 0; wdata_a = 32'hDEAD;
        rd_addr_a = {5'd2, 5'd1};
        q_a0.push_back(32'h1001);
        q_a1.push_back(32'h1002);
        step();
        clr_a = 0;
        chk("clr_busy_a", 64'(busy_a), 64'd1);
        rd_addr_a = {5'd0, 5'd0};
        wdata_a = 32'hFACE;
        wait_sweep("clr_sweep_a", 1'b0, 32);
        we_a = 0; rd_en_a = 0;
        for (int a = 0; a < 32; a++) begin
            rd_en_a = 2'b11;
            rd_addr_a = {5'(a), 5'(31 - a)};
            q_a0.push_back(32'hA5A5A5A5);
            q_a1.push_back(32'hA5A5A5A5);
            step();
        end
        rd_en_a = 0;

        // ---------------- Instance B (DEPTH=20) ----------------
        rst_n_b = 1;
        wait_sweep("init_sweep_b", 1'b1, 20);

        // Out-of-range write dropped, out-of-range read returns zero.
        we_b = 1; waddr_b = 25; wdata_b = 32'h77;
        rd_en_b = 2'b11; rd_addr_b = {5'd19, 5'd25};
        q_b0.push_back(32'h0);
        q_b1.push_back(32'h5A);
        step();
        we_b = 0;
        rd_addr_b = {5'd25, 5'd25};
        q_b0.push_back(32'h0);
        q_b1.push_back(32'h0);
        step();
        for (int a = 0; a < 20; a++) begin
            rd_addr_b = {5'(19 - a), 5'(a)};
            q_b0.push_back(32'h5A);
            q_b1.push_back(32'h5A);
            step();
        end
        rd_en_b = 0;

        // Reset mid-read clears rd_valid immediately.
        rd_en_b = 2'b01; rd_addr_b = {5'd0, 5'd3};
        step();
        rd_en_b = 0;
        chk("read_valid_b", 64'(rd_valid_b), 64'd1);
        rst_n_b = 0;
        #1;
        chk("rst_valid_b", 64'(rd_valid_b), 64'd0);
        chk("rst_busy_b", 64'(busy_b), 64'd1);
        chk("rst_data_b", rd_data_b, 64'd0);
        step();
        rst_n_b = 1;
        wait_sweep("rst_read_sweep_b", 1'b1, 20);

        // Reset mid-sweep restarts the full sweep.
        we_b = 1; waddr_b = 2; wdata_b = 32'h22;
        step();
        waddr_b = 15; wdata_b = 32'hF5;
        step();
        we_b = 0;
        clr_b = 1;
        step();
        clr_b = 0;
        repeat (10) step();
        rst_n_b = 0;
        #1;
        chk("mid_sweep_busy_b", 64'(busy_b), 64'd1);
        step();
        step();
        chk("mid_sweep_busy_hold_b", 64'(busy_b), 64'd1);
        chk("mid_sweep_valid_b", 64'(rd_valid_b), 64'd0);
        rst_n_b = 1;
        wait_sweep("mid_sweep_restart_b", 1'b1, 20);
        for (int a = 0; a < 20; a++) begin
            rd_en_b = 2'b11;
            rd_addr_b = {5'(a), 5'(19 - a)};
            q_b0.push_back(32'h5A);
            q_b1.push_back(32'h5A);
            step();
        end
        rd_en_b = 0;

        repeat (3) step();
        chk("pending_a0", 64'(q_a0.size()), 64'd0);
        chk("pending_a1", 64'(q_a1.size()), 64'd0);
        chk("pending_b0", 64'(q_b0.size()), 64'd0);
        chk("pending_b1", 64'(q_b1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
